// File: rtl/rptr_empty_lvl_if.sv
// rtl/rptr_empty_lvl_if.sv - read-side bundle between the FIFO read pointer block and its consumer
//
// Signals (all in the rclk domain):
//   rinc        read request from the consumer
//   rq2_wptr    Gray write pointer, already synchronised into rclk
//   rae_thresh  almost-empty threshold, binary
//   rudf_clr    clears the sticky underflow flag
//   raddr       binary memory read address
//   rptr        Gray read pointer, registered, for the write domain
//   rempty      FIFO empty, registered
//   raempty     almost-empty, registered
//   rlevel      words available, registered, 0..2^ADDRSIZE
//   rread       read accepted this cycle, combinational
//   rudf        sticky underflow, registered
// Modports: slave = pointer block, master = consumer / FIFO parent.

interface rptr_empty_lvl_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rae_thresh;
  logic                rudf_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                rread;
  logic                rudf;

  modport slave (
    input  rinc, rq2_wptr, rae_thresh, rudf_clr,
    output raddr, rptr, rempty, raempty, rlevel, rread, rudf
  );

  modport master (
    output rinc, rq2_wptr, rae_thresh, rudf_clr,
    input  raddr, rptr, rempty, raempty, rlevel, rread, rudf
  );
endinterface

// File: rtl/rptr_empty_lvl.sv
// rtl/rptr_empty_lvl.sv - async FIFO read pointer with empty, almost-empty, level and underflow
//
// Ports:
//   rclk    read-domain clock, all state on the rising edge
//   rrst_n  asynchronous active-low reset, synchronous release
//   bus     rptr_empty_lvl_if.slave read-side bundle (see interface header)
// Parameter ADDRSIZE: FIFO depth is 2^ADDRSIZE words, legal range 2..12.

module rptr_empty_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  rptr_empty_lvl_if.slave      bus
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] rlevelnext;

  // Only an accepted read advances the pointer; a read while empty is an underflow.
  assign bus.rread   = bus.rinc & ~bus.rempty;
  assign rbinnext    = rbin + {{ADDRSIZE{1'b0}}, bus.rread};
  assign rgraynext   = (rbinnext >> 1) ^ rbinnext;
  assign bus.raddr   = rbin[ADDRSIZE-1:0];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  // Written as a reduction of a shifted copy so no bit depends on another bit of wbin_s.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(bus.rq2_wptr >> i);
    end
  end

  // Modulo subtraction is exact because the write side never runs more than
  // 2^ADDRSIZE words ahead; a full FIFO lands on the MSB-only value.
  assign rlevelnext = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin        <= '0;
      bus.rptr    <= '0;
      bus.rempty  <= 1'b1;
      bus.raempty <= 1'b1;
      bus.rlevel  <= '0;
    end else begin
      rbin        <= rbinnext;
      bus.rptr    <= rgraynext;
      // Compared against the post-read pointer so the last read asserts empty with no bubble.
      bus.rempty  <= (rgraynext == bus.rq2_wptr);
      bus.raempty <= (rlevelnext <= bus.rae_thresh);
      bus.rlevel  <= rlevelnext;
    end
  end

  // Sticky underflow: a new underflow wins over a simultaneous clear.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bus.rudf <= 1'b0;
    end else if (bus.rinc && bus.rempty) begin
      bus.rudf <= 1'b1;
    end else if (bus.rudf_clr) begin
      bus.rudf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb/tb_rptr_empty_lvl.sv - directed and random checks of rptr_empty_lvl against a word-count model

module tb_rptr_empty_lvl;
  localparam int A = 4;
  localparam int DEPTH = 1 << A;

  logic rclk;
  logic rrst_n;

  rptr_empty_lvl_if #(.ADDRSIZE(A)) bus ();

  rptr_empty_lvl #(.ADDRSIZE(A)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Model: the FIFO is described by total words written and read so far.
  int  wcnt;
  int  rcnt;
  int  thresh;
  int  m_level;
  bit  m_empty;
  bit  m_aempty;
  bit  m_udf;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int x);
    int v;
    v = x % (2 * DEPTH);
    return v ^ (v >> 1);
  endfunction

  task automatic check_all(input string ph);
    check_eq({ph, "_raddr"},   int'(bus.raddr),   rcnt % DEPTH);
    check_eq({ph, "_rptr"},    int'(bus.rptr),    gray(rcnt));
    check_eq({ph, "_rempty"},  int'(bus.rempty),  int'(m_empty));
    check_eq({ph, "_raempty"}, int'(bus.raempty), int'(m_aempty));
    check_eq({ph, "_rlevel"},  int'(bus.rlevel),  m_level);
    check_eq({ph, "_rudf"},    int'(bus.rudf),    int'(m_udf));
  endtask

  task automatic model_reset();
    rcnt = 0; wcnt = 0; m_level = 0;
    m_empty = 1'b1; m_aempty = 1'b1; m_udf = 1'b0;
    bus.rq2_wptr = '0;
  endtask

  // One clock: drive inputs, check rread, clock, advance model, check outputs.
  task automatic step(input string ph, input bit inc, input bit clr);
    int exp_read;
    int prev_rptr;
    bus.rinc       = inc;
    bus.rudf_clr   = clr;
    bus.rq2_wptr   = (A+1)'(gray(wcnt));
    bus.rae_thresh = (A+1)'(thresh);
    #1;
    exp_read = (inc && !m_empty) ? 1 : 0;
    check_eq({ph, "_rread"}, int'(bus.rread), exp_read);
    prev_rptr = int'(bus.rptr);
    @(posedge rclk);
    if (inc && m_empty) m_udf = 1'b1;
    else if (clr)       m_udf = 1'b0;
    rcnt     = rcnt + exp_read;
    m_level  = wcnt - rcnt;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= thresh);
    #1;
    check_all(ph);
    if (exp_read == 1)
      check_eq({ph, "_rptr_hamming"}, $countones(prev_rptr ^ int'(bus.rptr)), 1);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b0;
    bus.rinc = 1'b0; bus.rudf_clr = 1'b0; bus.rae_thresh = '0;
    thresh = 0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    check_all("por");
    @(negedge rclk);
    rrst_n = 1'b1;

    // Underflow out of reset.
    for (int i = 0; i < 3; i++) step("udf_start", 1'b1, 1'b0);

    // Five words arrive, then drain them.
    wcnt = 5; thresh = 2;
    step("fill5", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("drain5", 1'b1, 1'b0);

    // Full FIFO from a clean pointer.
    do_reset();
    wcnt = 16; thresh = 2;
    step("full", 1'b0, 1'b0);
    check_eq("full_rlevel_const", int'(bus.rlevel), 16);
    for (int i = 0; i < 16; i++) step("full_drain", 1'b1, 1'b0);
    check_eq("full_rptr_const", int'(bus.rptr), 5'b11000);
    check_eq("full_raddr_wrap", int'(bus.raddr), 0);

    // 32 back-to-back reads, wrapping the binary pointer.
    wcnt = rcnt + 16;
    for (int i = 0; i < 32; i++) begin
      step("stream", 1'b1, 1'b0);
      wcnt = rcnt + 16;
    end

    // Drain, then set-wins-over-clear and a clean clear.
    while (wcnt != rcnt) step("drain", 1'b1, 1'b0);
    step("udf_set", 1'b1, 1'b0);
    step("udf_setclr", 1'b1, 1'b1);
    check_eq("udf_hold_const", int'(bus.rudf), 1);
    step("udf_clr", 1'b0, 1'b1);
    check_eq("udf_clear_const", int'(bus.rudf), 0);

    // Mid-stream reset with seven words pending.
    wcnt = rcnt + 7;
    step("lvl7", 1'b0, 1'b0);
    do_reset();

    // Random traffic with a legal writer.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1 && (wcnt - rcnt) < DEPTH)
        wcnt = wcnt + $urandom_range(1, DEPTH - (wcnt - rcnt));
      thresh = $urandom_range(0, DEPTH + 1);
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/rptr_empty_lvl.md
RPTR_EMPTY_LVL -- requirements
Module: rptr_empty_lvl

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, meaning FIFO depth = 2^ADDRSIZE words; legal range 2..12.
REQ-002 The block SHALL have the following ports, one per line, as name, direction, width, meaning:
- rclk  input  1  read-domain clock; all state on rising edge.
- rrst_n  input  1  reset, asynchronous, active-low.
- rinc  input  1  read request.
- rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already synchronised into rclk.
- rae_thresh  input  ADDRSIZE+1  almost-empty threshold, binary.
- rudf_clr  input  1  clears the sticky underflow flag.
- raddr  output  ADDRSIZE  binary memory read address.
- rptr  output  ADDRSIZE+1  Gray read pointer, registered, for the write domain.
- rempty  output  1  FIFO empty, registered.
- raempty  output  1  almost-empty, registered.
- rlevel  output  ADDRSIZE+1  words available, registered, 0..2^ADDRSIZE.
- rread  output  1  accepted read this cycle, combinational.
- rudf  output  1  sticky underflow, registered.

Function
REQ-003 The block SHALL hold an internal binary pointer rbin, ADDRSIZE+1 bits; raddr SHALL be rbin[ADDRSIZE-1:0].
REQ-004 rread SHALL equal rinc AND NOT rempty; this is the only condition that advances the pointer.
REQ-005 Next binary pointer rbinnext SHALL be rbin + rread, modulo 2^(ADDRSIZE+1); wrap from all-ones to zero is silent.
REQ-006 Next Gray pointer SHALL be rbinnext XOR (rbinnext >> 1); rbin and rptr SHALL both load next values every rclk edge.
REQ-007 rptr SHALL change at most one bit per cycle, including across wrap.
REQ-008 rempty SHALL be registered as (next Gray pointer == rq2_wptr); an accepted read of the last word SHALL assert rempty on the following edge with no bubble.
REQ-009 The block SHALL convert rq2_wptr to binary wbin_s combinationally by prefix XOR from the MSB.
REQ-010 rlevel SHALL register (wbin_s - rbinnext) modulo 2^(ADDRSIZE+1); with a legal write side, the value lies in 0..2^ADDRSIZE.
REQ-011 raempty SHALL register (next level <= rae_thresh); rae_thresh = 0 makes raempty equal rempty.
REQ-012 rempty = 1 SHALL imply rlevel = 0 in the same cycle, and rlevel = 0 SHALL imply rempty = 1.
REQ-013 rudf SHALL set on any edge where rinc = 1 and rempty = 1.
REQ-014 When rudf is set, it SHALL hold until an edge with rudf_clr = 1 and no new underflow; set SHALL take priority over a simultaneous clear.
REQ-015 A read attempted while empty SHALL NOT move rbin, rptr, or rlevel.
REQ-016 rq2_wptr and rae_thresh SHALL be sampled only through the registered next-state paths; no output other than rread SHALL depend combinationally on inputs.
REQ-017 A full FIFO SHALL report rlevel = 2^ADDRSIZE (MSB set, other bits 0), with rempty = 0 and raempty = 0 unless rae_thresh >= 2^ADDRSIZE.

Reset
REQ-018 While rrst_n = 0, outputs SHALL be: rbin = 0, rptr = 0, raddr = 0, rempty = 1, raempty = 1, rlevel = 0, rudf = 0.
REQ-019 Reset SHALL take effect asynchronously on assertion, with release synchronous to rclk.
REQ-020 Reset asserted mid-stream SHALL discard the pointer with no partial update; write-side reset coordination is the parent FIFO's responsibility.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, ADDRSIZE = 4 unless stated:
- Reset, then rq2_wptr = 0 and rinc = 1 for 3 cycles -> rempty = 1, rlevel = 0, raddr = 0, rudf = 1 after the first edge.
- rq2_wptr = Gray(5), rae_thresh = 2, rinc = 0 -> next edge rempty = 0, rlevel = 5, raempty = 0.
- Then rinc = 1 for 5 cycles -> raddr steps 0..4; raempty asserts when level reaches 2; rempty = 1 and rlevel = 0 after the 5th read.
- rq2_wptr = Gray(16), i.e. full -> rlevel = 16 (5'b10000); read 16 words -> rptr = Gray(16) = 5'b11000; raddr wraps to 0.
- Continuous reading across 32 accepted reads -> each rptr transition has Hamming distance 1; rbin wraps from 31 to 0.
- rudf = 1 with rudf_clr = 1 and rinc = 1 while empty in the same cycle -> rudf stays 1; next cycle rudf_clr = 1 and rinc = 0 -> rudf = 0.
- rrst_n pulsed low for half a cycle with rlevel = 7 -> immediate rempty = 1, rlevel = 0, rptr = 0.
